// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-port scheduler sharing one combinational ALU (valid/ready in, tagged response out)
// Optional feature: define ALU_SCHED_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_sched #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNTW-1:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;
  logic   grant_any;
  logic   grant_id;

  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = 1'b0;
`ifdef ALU_SCHED_RR_EN
    // On a tie the port that did not win last time goes next.
    if (req0_valid && req1_valid)
      grant_id = ~last_grant;
    else
      grant_id = req1_valid;
`else
    grant_id = ~req0_valid & req1_valid;
`endif
  end

`ifndef ALU_SCHED_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Ready is forced low while reset is held so no handshake can be seen.
  assign req0_ready = RST_n && (state == IDLE) && grant_any && !grant_id;
  assign req1_ready = RST_n && (state == IDLE) && grant_any &&  grant_id;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      busy       <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            alu_op     <= grant_id ? req1_op : req0_op;
            alu_a      <= grant_id ? req1_a  : req0_a;
            alu_b      <= grant_id ? req1_b  : req0_b;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-port scheduler that shares the single combinational ALU (ALUOp/A/B → result/zero) between two requesters, e.g. the main datapath (port 0) and the branch/address unit (port 1). It arbitrates requests, registers the winning operands into the ALU, captures result/zero, and returns them on a valid/ready response channel tagged with the requester id. It sits between the requesters and the ALU instance, which it drives exclusively.

## Interface
- WIDTH, 32, operand/result width
- OPW, 3, ALU opcode width
- CNTW, 16, completed-operation counter width

- CLK  in  1  clock, rising edge
- RST_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request valid per port
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&&ready
- req0_op / req1_op  in  OPW  ALU opcode
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- alu_op  out  OPW  to ALU ALUOp
- alu_a, alu_b  out  WIDTH  to ALU A/B
- alu_result  in  WIDTH  from ALU result
- alu_zero  in  1  from ALU zero
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&&ready
- rsp_id  out  1  port that issued the request
- rsp_result  out  WIDTH  captured result
- rsp_zero  out  1  captured zero flag
- busy  out  1  high in EXEC or RESP
- op_count  out  CNTW  completed responses, wraps

## Operation
- FSM: IDLE → EXEC → RESP → IDLE. One operation in flight; opcode-agnostic (no opcode decoding).
- IDLE: grant computed combinationally from req*_valid and last_grant; only granted port sees ready=1. On handshake: latch op/a/b into alu_op/alu_a/alu_b, latch id, update last_grant, go EXEC.
- EXEC: ALU inputs stable from registers; on clock edge capture alu_result/alu_zero into rsp_result/rsp_zero, go RESP.
- RESP: rsp_valid=1, rsp_* stable. On rsp_ready: op_count += 1 (mod 2^CNTW), go IDLE. Both req*_ready are 0 in EXEC and RESP.
- Arbitration with round-robin: if both valid, grant the port ≠ last_grant; if one valid, grant it. last_grant resets to 1, so port 0 wins the first tie.
- alu_op/alu_a/alu_b hold their last value outside EXEC (no toggling while idle).
- Requesters keep valid and payload stable until ready; the scheduler samples payload only at the handshake edge.
- Reset values: state IDLE, req*_ready 0 while RST_n low, alu_op 0, alu_a 0, alu_b 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, busy 0, op_count 0, last_grant 1.
- Reset asserted mid-operation: in-flight op discarded, no response issued, all outputs to reset values immediately.

## Timing
- Accept at edge N (valid&&ready high before N); EXEC during cycle N..N+1; rsp_valid high from edge N+1.
- Latency request-accept to rsp_valid: 1 cycle after accept edge (2 edges from valid seen in IDLE with ready).
- Minimum issue interval: 3 cycles (IDLE, EXEC, RESP with rsp_ready already high).
- rsp_ready low: RESP holds indefinitely, rsp_* unchanged, no new grants.
- op_count increments on the rsp handshake edge; CNTW-bit wrap from all-ones to 0.
- ALU path is combinational within the EXEC cycle; EXEC is exactly 1 cycle.

## Configuration
- ALU_SCHED_RR_EN defined: round-robin arbitration as above.
- ALU_SCHED_RR_EN undefined: fixed priority, port 0 always wins when both valid; last_grant still updated but ignored; port 1 may starve.

## Test plan
- req0 op=0 a=10 b=20 alone (team ALU: 0=add) → one cycle after accept rsp_valid=1, rsp_id=0, rsp_result=30, rsp_zero=0; op_count=1 after rsp handshake.
- req1 op=1 a=9 b=9 (1=sub) → rsp_id=1, rsp_result=0, rsp_zero=1; then op=1 a=9 b=6 → rsp_result=3, rsp_zero=0.
- Both ports valid continuously, RR_EN defined, rsp_ready=1 → responses alternate ids 0,1,0,1, one accept every 3 cycles; without the macro → all ids 0, req1_ready never high.
- rsp_ready held low 5 cycles in RESP with both req valid → rsp_* stable, both req*_ready=0, busy=1; release → handshake, next grant in the following IDLE cycle.
- RST_n pulsed low during EXEC → immediately rsp_valid=0, alu_* =0, busy=0, op_count=0; no response for the dropped op after release.
- Preload via 65535 completed ops (or CNTW=4 build: 15 ops) then one more → op_count wraps to 0.
